// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared types for the pipeline hazard controller.
//   fwd_sel_t    - operand source select (regfile / EX result / MEM Dw)
//   ctrl_state_t - controller FSM state encoding
//   stage_info_t - per-stage scoreboard entry {valid, rd, regwrite, memread}
//   XZR          - zero register, never a hazard source
//   src_hit()    - true when a stage entry will write the register a read port needs
package pipeline_ctrl_pkg;

  localparam logic [4:0] XZR = 5'd31;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EX  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } ctrl_state_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regwrite;
    logic       memread;
  } stage_info_t;

  localparam stage_info_t STAGE_BUBBLE = '0;

  function automatic logic src_hit(stage_info_t e, logic [4:0] src, logic used);
    return e.valid & e.regwrite & (e.rd == src) & (src != XZR) & used;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: RF-stage request and hazard-control response bundle.
//   Inputs to the controller : id_valid, id_rn, id_ab, id_uses_rn, id_uses_ab,
//                              id_rd, id_regwrite, id_memread, ex_branch_taken
//   Outputs from controller  : stall_if, stall_id, flush_if, bubble_ex,
//                              fwd_a, fwd_b, ctrl_state, stall_count
// master = pipeline side driving RF-stage info, slave = hazard controller.
interface pipeline_hazard_ctrl_if;
  logic        id_valid;
  logic [4:0]  id_rn;
  logic [4:0]  id_ab;
  logic        id_uses_rn;
  logic        id_uses_ab;
  logic [4:0]  id_rd;
  logic        id_regwrite;
  logic        id_memread;
  logic        ex_branch_taken;
  logic        stall_if;
  logic        stall_id;
  logic        flush_if;
  logic        bubble_ex;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic [1:0]  ctrl_state;
  logic [31:0] stall_count;

  modport master (
    output id_valid, id_rn, id_ab, id_uses_rn, id_uses_ab,
           id_rd, id_regwrite, id_memread, ex_branch_taken,
    input  stall_if, stall_id, flush_if, bubble_ex,
           fwd_a, fwd_b, ctrl_state, stall_count
  );

  modport slave (
    input  id_valid, id_rn, id_ab, id_uses_rn, id_uses_ab,
           id_rd, id_regwrite, id_memread, ex_branch_taken,
    output stall_if, stall_id, flush_if, bubble_ex,
           fwd_a, fwd_b, ctrl_state, stall_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_scoreboard.sv
// hazard_scoreboard: three-entry EX/MEM/WB destination tracker and match logic.
//   clk, reset     - pipeline clock, synchronous active-high reset
//   id_info        - destination info of the instruction in RF
//   insert_bubble  - load an invalid entry into EX instead of id_info
//   src_a/use_a,
//   src_b/use_b    - RF-stage read registers and their port-used qualifiers
//   ex_hit_*/mem_hit_* - read port matches a pending writer in EX / MEM
//   ex_is_load     - the EX entry is a load
module hazard_scoreboard
  import pipeline_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  stage_info_t id_info,
  input  logic        insert_bubble,
  input  logic [4:0]  src_a,
  input  logic        use_a,
  input  logic [4:0]  src_b,
  input  logic        use_b,
  output logic        ex_hit_a,
  output logic        ex_hit_b,
  output logic        mem_hit_a,
  output logic        mem_hit_b,
  output logic        ex_is_load
);

  stage_info_t ex_q, mem_q, wb_q;
  logic        wb_q_unused;

  // NOTE: sequential state uses non-blocking assignments so the shift reads
  // every stage's old value before any stage is overwritten.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q  <= STAGE_BUBBLE;
      mem_q <= STAGE_BUBBLE;
      wb_q  <= STAGE_BUBBLE;
    end else begin
      ex_q  <= insert_bubble ? STAGE_BUBBLE : id_info;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  assign ex_hit_a   = src_hit(ex_q,  src_a, use_a);
  assign ex_hit_b   = src_hit(ex_q,  src_b, use_b);
  assign mem_hit_a  = src_hit(mem_q, src_a, use_a);
  assign mem_hit_b  = src_hit(mem_q, src_b, use_b);
  assign ex_is_load = ex_q.memread;

  // The WB writer is tracked but never acted on: the regfile writes on the
  // falling edge, so an RF-stage read in the same cycle already sees it.
  assign wb_q_unused = ^wb_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall / flush / forwarding controller for a 5-stage pipe.
//   clk    - pipeline clock
//   reset  - synchronous, active-high; all outputs read 0 while asserted
//   bus    - pipeline_hazard_ctrl_if.slave (RF-stage info in, control out)
// Build option: define HAZARD_FORWARDING_EN to forward from EX/MEM and stall
// only on load-use; without it every EX/MEM dependency stalls and fwd_* is 00.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  pipeline_hazard_ctrl_if.slave   bus
);

  stage_info_t id_info;
  logic        ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b, ex_is_load;
  logic        hazard, stall, flush, bubble;
  fwd_sel_t    fwd_a, fwd_b;
  ctrl_state_t state_q, state_d;
  logic [31:0] stall_count_q;

  assign id_info = '{valid:    bus.id_valid,
                     rd:       bus.id_rd,
                     regwrite: bus.id_regwrite,
                     memread:  bus.id_memread};

  hazard_scoreboard u_scoreboard (
    .clk           (clk),
    .reset         (reset),
    .id_info       (id_info),
    .insert_bubble (bubble),
    .src_a         (bus.id_rn),
    .use_a         (bus.id_uses_rn),
    .src_b         (bus.id_ab),
    .use_b         (bus.id_uses_ab),
    .ex_hit_a      (ex_hit_a),
    .ex_hit_b      (ex_hit_b),
    .mem_hit_a     (mem_hit_a),
    .mem_hit_b     (mem_hit_b),
    .ex_is_load    (ex_is_load)
  );

`ifdef HAZARD_FORWARDING_EN
  // Only a load in EX cannot be bypassed; its data appears at MEM next cycle.
  assign hazard = ex_is_load & (ex_hit_a | ex_hit_b);
  assign fwd_a  = ex_hit_a ? FWD_EX : (mem_hit_a ? FWD_MEM : FWD_RF);
  assign fwd_b  = ex_hit_b ? FWD_EX : (mem_hit_b ? FWD_MEM : FWD_RF);
`else
  logic ex_is_load_unused;
  assign ex_is_load_unused = ex_is_load;
  // No bypass paths: wait until the producer reaches WB.
  assign hazard = ex_hit_a | ex_hit_b | mem_hit_a | mem_hit_b;
  assign fwd_a  = FWD_RF;
  assign fwd_b  = FWD_RF;
`endif

  // Next-state and control priority: a taken branch kills the RF instruction,
  // so any stall it would have caused is dropped.
  always_comb begin
    // NOTE: defaults are assigned before any branch so no path leaves a
    // variable unassigned, which would infer a latch.
    flush   = bus.ex_branch_taken;
    stall   = 1'b0;
    state_d = ST_RUN;
    if (!flush) begin
      stall = bus.id_valid & hazard;
    end
    bubble = stall | flush;
    if (flush) begin
      state_d = ST_FLUSH;
    end else if (stall) begin
      state_d = ST_STALL;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count_q <= '0;
    end else if (stall && (stall_count_q != 32'hFFFF_FFFF)) begin
      stall_count_q <= stall_count_q + 32'd1;
    end
  end

  // Outputs are forced to zero while reset is held, even before the first
  // reset edge has cleared the registers.
  always_comb begin
    bus.stall_if    = 1'b0;
    bus.stall_id    = 1'b0;
    bus.flush_if    = 1'b0;
    bus.bubble_ex   = 1'b0;
    bus.fwd_a       = FWD_RF;
    bus.fwd_b       = FWD_RF;
    bus.ctrl_state  = ST_RUN;
    bus.stall_count = '0;
    if (!reset) begin
      bus.stall_if    = stall;
      bus.stall_id    = stall;
      bus.flush_if    = flush;
      bus.bubble_ex   = bubble;
      bus.fwd_a       = fwd_a;
      bus.fwd_b       = fwd_b;
      bus.ctrl_state  = state_q;
      bus.stall_count = stall_count_q;
    end
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Ports SHALL be `clk` and `reset`: one clock, synchronous active-high reset; all state updates on posedge `clk`.
REQ-002 `clk  input  1  pipeline clock`.
REQ-003 `reset  input  1  synchronous, active-high`.
REQ-004 `id_valid  input  1  RF-stage instruction is real (not a bubble)`.
REQ-005 `id_rn  input  5  RF-stage A-read register`; `id_ab  input  5  RF-stage B-read register`.
REQ-006 `id_uses_rn  input  1`; `id_uses_ab  input  1  read-port-used qualifiers`.
REQ-007 `id_rd  input  5`; `id_regwrite  input  1`; `id_memread  input  1  RF-stage destination info (load = id_memread)`.
REQ-008 `ex_branch_taken  input  1  EX-stage branch/PC_select resolved taken`.
REQ-009 `stall_if  output  1  hold PC and IF register`; `stall_id  output  1  hold RF-stage inputs`.
REQ-010 `flush_if  output  1  clear IF register at next edge`; `bubble_ex  output  1  load NOP into RF/EX register`.
REQ-011 `fwd_a  output  2`; `fwd_b  output  2  operand select: 00 regfile, 01 EX result, 10 MEM Dw`.
REQ-012 `ctrl_state  output  2  FSM state`; `stall_count  output  32  stall-cycle counter`.

Function
REQ-013 Internal scoreboard SHALL hold entries ex_q, mem_q, wb_q, each {valid, rd, regwrite, memread}, advancing every cycle: mem_q<=ex_q, wb_q<=mem_q.
REQ-014 ex_q SHALL load ID info when neither stall nor flush is asserted, else load an invalid bubble.
REQ-015 Hazard match SHALL require entry.valid & entry.regwrite & entry.rd==src & src!=5'd31 & port-used qualifier; X31 never hazards.
REQ-016 WB-stage matches SHALL NOT stall or forward; the regfile writes on the falling edge.
REQ-017 Forwarding (combinational): ex_q match -> 01; else mem_q match -> 10; else 00. EX takes priority over MEM.
REQ-018 Load-use: ex_q match with ex_q.memread SHALL assert stall_if, stall_id and bubble_ex for exactly one cycle; the next cycle forwards 10.
REQ-019 Taken branch: ex_branch_taken SHALL assert flush_if and bubble_ex in the same cycle, with stall_if=stall_id=0.
REQ-020 A simultaneous branch and stall SHALL resolve as flush; the stall is dropped.
REQ-021 Stalls SHALL be ignored when id_valid=0.
REQ-022 FSM states: RUN=0, STALL=1, FLUSH=2.
  - Next state = FLUSH if branch taken; else STALL if stall; else RUN.
  - FLUSH lasts one cycle unless another branch is taken.
REQ-023 stall_count SHALL increment once per cycle with stall_id=1 and saturate at 32'hFFFF_FFFF (no wrap).

Reset
REQ-024 Reset SHALL set:
  - ex_q, mem_q, wb_q invalid;
  - state RUN;
  - stall_count 0.
REQ-025 During reset, all outputs SHALL be 0. Reset mid-stall or mid-flush SHALL abandon the operation with no residual stall the following cycle.

Configuration
REQ-026 Macro HAZARD_FORWARDING_EN SHALL select the hazard policy.
  - Defined: behaviour per REQ-017/018.
  - Undefined: fwd_a=fwd_b=00 always; any ex_q or mem_q match stalls until the producer reaches WB (load or not, up to 2 cycles).

Structure
REQ-027 Package `pipeline_ctrl_pkg` SHALL contain fwd_sel_t (2-bit enum), ctrl_state_t (2-bit enum), stage_info_t struct, and XZR=5'd31.
REQ-028 Sub-module `hazard_scoreboard` SHALL hold the three-entry shift register and the match logic. The top level holds the FSM, priority, and counter.

Verification
REQ-029 ADD X1 then SUB X2,X1,X3 back-to-back -> fwd_a=01 the cycle SUB is in RF, no stall; with macro undefined -> stall_id high 2 cycles, stall_count=2.
REQ-030 LDUR X4 then ADD X5,X4,X4 -> one cycle stall_if=stall_id=bubble_ex=1, then fwd_a=fwd_b=10, stall_count=1.
REQ-031 ex_branch_taken=1 with a load-use pending in the same cycle -> flush_if=bubble_ex=1, stall_id=0, ctrl_state=FLUSH the next cycle, then RUN.
REQ-032 Producer rd=31, consumer reads X31 -> fwd 00, no stall.
REQ-033 Reset asserted during STALL -> next cycle all outputs 0, ctrl_state=RUN, stall_count=0.
REQ-034 Force stall_count=32'hFFFF_FFFE, then 3 stall cycles -> stall_count holds 32'hFFFF_FFFF.
